morse_encoder: RTL and testbench

- Transmit-side counterpart of the button-driven Morse decoder.
- Accepts one ASCII letter per handshake, looks up its Morse code word and keys it out on `key_out` with standard unit timing.
- `key_out` drives an LED (or a buzzer through the optional tone feature) on the Basys3.
- Uses the decoder's 10-bit code-word format, so a decoded word can be looped straight back for retransmission.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_char_rom.sv | 55 +++++
 rtl/morse_encoder.sv | 162 ++++++++++++++++
 tb/tb_morse_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants, state encoding and code-word builder for the Morse encoder.
// Code word layout: bits[1:0]=00, symbols in [3:2],[5:4],[7:6],[9:8], sent LSB pair first.
package morse_pkg;

    localparam int CODE_W = 10;

    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b11;
    localparam logic [1:0] SYM_END  = 2'b00;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int SYM_GAP_UNITS  = 1;
    localparam int CHAR_GAP_UNITS = 3;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        CHAR_GAP
    } state_e;

    // s1 is keyed first, so it lands in the lowest symbol slot.
    function automatic logic [CODE_W-1:0] sym_word(input logic [1:0] s1, input logic [1:0] s2,
                                                   input logic [1:0] s3, input logic [1:0] s4);
        return {s4, s3, s2, s1, 2'b00};
    endfunction

endpackage

// File: rtl/morse_char_rom.sv
// Combinational ASCII-to-code-word lookup; folds a-z onto A-Z, flags anything else invalid.
module morse_char_rom
    import morse_pkg::*;
(
    input  logic [7:0]        char_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o
);

    localparam logic [1:0] D = SYM_DOT;
    localparam logic [1:0] H = SYM_DASH;
    localparam logic [1:0] X = SYM_END;

    logic [7:0] upper;

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves a latch behind.
        upper   = char_i;
        code_o  = '0;
        if (char_i >= 8'h61 && char_i <= 8'h7A) begin
            upper = char_i - 8'h20;
        end
        valid_o = (upper >= 8'h41) && (upper <= 8'h5A);
        case (upper)
            "A": code_o = sym_word(D, H, X, X);
            "B": code_o = sym_word(H, D, D, D);
            "C": code_o = sym_word(H, D, H, D);
            "D": code_o = sym_word(H, D, D, X);
            "E": code_o = sym_word(D, X, X, X);
            "F": code_o = sym_word(D, D, H, D);
            "G": code_o = sym_word(H, H, D, X);
            "H": code_o = sym_word(D, D, D, D);
            "I": code_o = sym_word(D, D, X, X);
            "J": code_o = sym_word(D, H, H, H);
            "K": code_o = sym_word(H, D, H, X);
            "L": code_o = sym_word(D, H, D, D);
            "M": code_o = sym_word(H, H, X, X);
            "N": code_o = sym_word(H, D, X, X);
            "O": code_o = sym_word(H, H, H, X);
            "P": code_o = sym_word(D, H, H, D);
            "Q": code_o = sym_word(H, H, D, H);
            "R": code_o = sym_word(D, H, D, X);
            "S": code_o = sym_word(D, D, D, X);
            "T": code_o = sym_word(H, X, X, X);
            "U": code_o = sym_word(D, D, H, X);
            "V": code_o = sym_word(D, D, D, H);
            "W": code_o = sym_word(D, H, H, X);
            "X": code_o = sym_word(H, D, D, H);
            "Y": code_o = sym_word(H, D, H, H);
            "Z": code_o = sym_word(H, H, D, D);
            default: code_o = '0;
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Keys out one ASCII letter per handshake as Morse on key_out with unit timing.
// Optional buzzer output tone_out is built only when MORSE_TONE_EN is defined.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int UNIT_CYCLES = 10000000,
    parameter int TONE_HZ     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              start,
    output logic              ready,
    output logic              key_out,
    output logic              done,
    output logic              err,
    output logic [CODE_W-1:0] code_out
`ifdef MORSE_TONE_EN
    ,
    output logic              tone_out
`endif
);

    localparam int TIMER_W = $clog2(CHAR_GAP_UNITS * UNIT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] DOT_LAST      = TIMER_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DASH_LAST     = TIMER_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SYM_GAP_LAST  = TIMER_W'(SYM_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CHAR_GAP_LAST = TIMER_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

    if (UNIT_CYCLES < 1 || TONE_HZ < 1 || CLK_HZ < 2 * TONE_HZ) begin : g_bad_params
        $error("morse_encoder: illegal parameter combination");
    end

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CODE_W-1:0]   shift_q, shift_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CODE_W-1:0]   rom_code;
    logic                rom_valid;
    logic [TIMER_W-1:0]  mark_last;

    morse_char_rom u_rom (
        .char_i  (char_in),
        .code_o  (rom_code),
        .valid_o (rom_valid)
    );

    // The symbol being keyed always sits in [3:2] of the shift register.
    assign mark_last = (shift_q[3:2] == SYM_DASH) ? DASH_LAST : DOT_LAST;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shift_d = shift_q;
        code_d  = code_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // ready low in IDLE marks the one-cycle load slot after an accept.
                if (!ready_q) begin
                    state_d = MARK;
                    timer_d = '0;
                end else if (start) begin
                    if (rom_valid) begin
                        shift_d = rom_code;
                        code_d  = rom_code;
                        ready_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (timer_q == mark_last) begin
                    timer_d = '0;
                    shift_d = shift_q >> 2;
                    state_d = (shift_q[5:4] == SYM_END) ? CHAR_GAP : SPACE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            SPACE: begin
                if (timer_q == SYM_GAP_LAST) begin
                    timer_d = '0;
                    state_d = MARK;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            CHAR_GAP: begin
                if (timer_q == CHAR_GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    code_d  = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so every register sees the pre-edge value of its peers.
        if (rst) begin
            // NOTE: the shift register is cleared too; it is only read in MARK, but a known value keeps simulation X-free.
            state_q <= IDLE;
            timer_q <= '0;
            shift_q <= '0;
            code_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign key_out  = (state_q == MARK);
    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign code_out = code_q;

`ifdef MORSE_TONE_EN
    localparam int TONE_DIV = CLK_HZ / (2 * TONE_HZ);
    localparam int TONE_W   = $clog2(TONE_DIV + 1);

    logic [TONE_W-1:0] tone_cnt_q;
    logic              tone_q;

    always_ff @(posedge clk) begin
        if (rst || !key_out) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
            tone_cnt_q <= '0;
            tone_q     <= ~tone_q;
        end else begin
            tone_cnt_q <= tone_cnt_q + TONE_W'(1);
        end
    end

    // Gate with key_out so the buzzer is silent the instant the mark ends.
    assign tone_out = tone_q & key_out;
`endif

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder at UNIT_CYCLES=4: per-cycle model compare plus
// directed literal checks on timing, error handling, busy rejection and mid-run reset.
module tb_morse_encoder;

    localparam int UNIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       ready, key_out, done, err;
    logic [9:0] code_out;
`ifdef MORSE_TONE_EN
    logic       tone_out;
`endif

    always #5 clk = ~clk;

    morse_encoder #(
        .CLK_HZ      (100),
        .UNIT_CYCLES (UNIT),
        .TONE_HZ     (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .char_in  (char_in),
        .start    (start),
        .ready    (ready),
        .key_out  (key_out),
        .done     (done),
        .err      (err),
        .code_out (code_out)
`ifdef MORSE_TONE_EN
        ,
        .tone_out (tone_out)
`endif
    );

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    function automatic bit lookup(input logic [7:0] c, output string m);
        int idx;
        m = "";
        if (c >= 8'h41 && c <= 8'h5A) idx = int'(c) - 65;
        else if (c >= 8'h61 && c <= 8'h7A) idx = int'(c) - 97;
        else return 1'b0;
        m = morse_tab[idx];
        return 1'b1;
    endfunction

    function automatic logic [9:0] model_code(input string m);
        logic [9:0] w = '0;
        for (int i = 0; i < m.len(); i++) begin
            w[2*i+2 +: 2] = (m[i] == "-") ? 2'b11 : 2'b01;
        end
        return w;
    endfunction

    bit         m_key = 1'b0, m_ready = 1'b1, m_done = 1'b0, m_err = 1'b0, m_live = 1'b0;
    logic [9:0] m_code = '0;
    bit         m_seq [$];

    always @(posedge clk) begin
        string m;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_seq.delete();
            m_key   = 1'b0;
            m_ready = 1'b1;
            m_code  = '0;
            m_live  = 1'b1;
        end else if (!m_ready) begin
            if (m_seq.size() > 0) begin
                m_key = m_seq.pop_front();
            end else begin
                m_key   = 1'b0;
                m_ready = 1'b1;
                m_done  = 1'b1;
                m_code  = '0;
            end
        end else if (start) begin
            if (lookup(char_in, m)) begin
                m_code  = model_code(m);
                m_ready = 1'b0;
                m_key   = 1'b0;
                for (int i = 0; i < m.len(); i++) begin
                    for (int k = 0; k < ((m[i] == "-") ? 3 : 1) * UNIT; k++) m_seq.push_back(1'b1);
                    for (int k = 0; k < ((i == m.len() - 1) ? 3 : 1) * UNIT; k++) m_seq.push_back(1'b0);
                end
            end else begin
                m_err = 1'b1;
            end
        end
    end

    // ---------------- compare + activity monitor ----------------
    int ready_low = 0, key_high = 0, done_cnt = 0, err_cnt = 0, gap_at_done = 0;
    bit cur_val = 1'b0;
    int cur_len = 0;
    bit run_val [$];
    int run_len [$];

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_key",   key_out,  m_key);
            check("cmp_ready", ready,    m_ready);
            check("cmp_done",  done,     m_done);
            check("cmp_err",   err,      m_err);
            check("cmp_code",  code_out, m_code);
        end
        if (!ready) ready_low++;
        if (key_out) key_high++;
        if (err) err_cnt++;
        if (done) begin
            done_cnt++;
            gap_at_done = cur_val ? 0 : cur_len;
        end
        if (key_out === cur_val) begin
            cur_len++;
        end else begin
            run_val.push_back(cur_val);
            run_len.push_back(cur_len);
            cur_val = key_out;
            cur_len = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        char_in = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int snap = done_cnt;
        int n    = 0;
        while (done_cnt == snap && n < budget) begin
            tick();
            n++;
        end
        check(name, done_cnt - snap, 1);
    endtask

    task automatic check_run(input string name, input int idx, input bit val, input int len);
        check({name, "_val"}, (idx < run_val.size()) ? run_val[idx] : ~val, val);
        check({name, "_len"}, (idx < run_len.size()) ? run_len[idx] : 0, len);
    endtask

    task automatic run_letter_a(input logic [7:0] c, input string tag);
        int n   = run_len.size();
        int rl0 = ready_low;
        send(c);
        check({tag, "_code"}, code_out, 10'b0000110100);
        wait_done(80, {tag, "_done"});
        check_run({tag, "_dot"},  n + 1, 1'b1, 4);
        check_run({tag, "_gap"},  n + 2, 1'b0, 4);
        check_run({tag, "_dash"}, n + 3, 1'b1, 12);
        check({tag, "_trail"}, gap_at_done, 12);
        check({tag, "_ready_low"}, ready_low - rl0, 33);
    endtask

    initial begin
        int rl0, kh0, d0, e0, n;

        // Pin the model against hand-derived code words.
        check("model_A", model_code(morse_tab[0]), 10'b0000110100);
        check("model_E", model_code(morse_tab[4]), 10'b0000000100);

        tick();
        check("rst_ready", ready, 1);
        check("rst_key",   key_out, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_code",  code_out, 0);
        tick();
        rst = 1'b0;
        tick();

        // 'E': one dot then the 3-unit trailing gap.
        rl0 = ready_low; kh0 = key_high; d0 = done_cnt;
        send("E");
        check("E_code", code_out, 10'b0000000100);
        wait_done(60, "E_done");
        check("E_ready_low", ready_low - rl0, 17);
        check("E_key_high",  key_high - kh0, 4);
        check("E_trail",     gap_at_done, 12);
        repeat (3) tick();
        check("E_done_once", done_cnt - d0, 1);

        // 'A' and lower-case 'a' must key identically.
        run_letter_a(8'h41, "A");
        tick();
        run_letter_a(8'h61, "a");
        tick();

        // Unsupported '#'.
        rl0 = ready_low; kh0 = key_high; d0 = done_cnt; e0 = err_cnt;
        send("#");
        repeat (4) tick();
        check("hash_err",       err_cnt - e0, 1);
        check("hash_done",      done_cnt - d0, 0);
        check("hash_key_high",  key_high - kh0, 0);
        check("hash_ready_low", ready_low - rl0, 0);

        // 'T' offered while 'O' is busy is ignored.
        n = run_len.size(); rl0 = ready_low; kh0 = key_high;
        send("O");
        repeat (8) tick();
        send("T");
        wait_done(120, "O_done");
        check_run("O_dash1", n + 1, 1'b1, 12);
        check_run("O_gap1",  n + 2, 1'b0, 4);
        check_run("O_dash2", n + 3, 1'b1, 12);
        check_run("O_gap2",  n + 4, 1'b0, 4);
        check_run("O_dash3", n + 5, 1'b1, 12);
        check("O_trail",     gap_at_done, 12);
        check("O_ready_low", ready_low - rl0, 57);
        repeat (6) tick();
        check("O_key_high",  key_high - kh0, 36);

        // Back-to-back: start held through the done cycle restarts immediately.
        n = run_len.size();
        char_in = "E";
        start   = 1'b1;
        wait_done(60, "b2b_done1");
        wait_done(60, "b2b_done2");
        start = 1'b0;
        check_run("b2b_mark1", n + 1, 1'b1, 4);
        check_run("b2b_gap",   n + 2, 1'b0, 14);
        check_run("b2b_mark2", n + 3, 1'b1, 4);
        repeat (3) tick();

        // Reset during the second dash of 'O', then a clean 'E'.
        send("O");
        repeat (19) tick();
        check("O_in_dash2", key_out, 1);
        rst = 1'b1;
        tick();
        check("midrst_key",   key_out, 0);
        check("midrst_ready", ready, 1);
        check("midrst_code",  code_out, 0);
        rst = 1'b0;
        tick();
        kh0 = key_high; rl0 = ready_low;
        send("E");
        wait_done(60, "postrst_done");
        check("postrst_key_high",  key_high - kh0, 4);
        check("postrst_ready_low", ready_low - rl0, 17);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
